instr_fetch_issue: RTL and testbench

INSTR_FETCH_ISSUE -- requirements
Module: instr_fetch_issue

---
 rtl/instr_fetch_issue.sv | 162 ++++++++++++++++
 tb/tb_instr_fetch_issue.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_issue.sv
// Instruction fetch/issue sequencer with a call/return stack.
// Define INSTR_FETCH_RS_CHECK_EN for checked return-stack overflow/underflow (halts with rs_err).
module instr_fetch_issue #(
  parameter int unsigned PC_W     = 10,
  parameter int unsigned RS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            imem_rd,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  output logic [15:0]     instr,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic            halted,
  output logic            rs_err
);

  localparam int unsigned SP_W  = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RS_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CAPT  = 3'd2,
    S_ISSUE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [SP_W-1:0]   sp_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [PC_W-1:0]   rs_mem [RS_DEPTH];

  logic              do_push, do_pop, err_set;
  logic              push_blocked, pop_blocked;
  logic [2:0]        grp, op;
  logic [9:0]        imm_raw;
  logic [PC_W-1:0]   imm, pc_inc;
  logic [SP_W-1:0]   sp_dec;

  // Decode straight from the memory bus; the same word is captured into instr in CAPT.
  assign grp     = imem_data[15:13];
  assign op      = imem_data[12:10];
  assign imm_raw = imem_data[9:0];
  assign imm     = PC_W'(imm_raw);
  assign pc_inc  = pc_q + PC_W'(1);
  assign sp_dec  = sp_q - SP_W'(1);

`ifdef INSTR_FETCH_RS_CHECK_EN
  assign push_blocked = (cnt_q == CNT_FULL);
  assign pop_blocked  = (cnt_q == '0);
`else
  assign push_blocked = 1'b0;
  assign pop_blocked  = 1'b0;
`endif

  // Next-state, next-pc and stack control.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    do_push = 1'b0;
    do_pop  = 1'b0;
    err_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: state_d = S_CAPT;
      S_CAPT: begin
        case (grp)
          3'b110: begin
            if (push_blocked) begin
              err_set = 1'b1;
              state_d = S_HALT;
            end else begin
              do_push = 1'b1;
              pc_d    = imm;
              state_d = S_FETCH;
            end
          end
          3'b111: begin
            if (op == 3'b000) begin
              if (pop_blocked) begin
                err_set = 1'b1;
                state_d = S_HALT;
              end else begin
                do_pop  = 1'b1;
                pc_d    = rs_mem[sp_dec];
                state_d = S_FETCH;
              end
            end else if (op == 3'b111) begin
              state_d = S_HALT;
            end else begin
              pc_d    = pc_inc;
              state_d = S_FETCH;
            end
          end
          default: state_d = S_ISSUE;
        endcase
      end
      S_ISSUE: begin
        if (instr_ready) begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // State, pc, registered outputs and return stack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      sp_q        <= '0;
      cnt_q       <= '0;
      imem_rd     <= 1'b0;
      imem_addr   <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      rs_mem      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      imem_rd     <= (state_d == S_FETCH);
      instr_valid <= (state_d == S_ISSUE);
      halted      <= (state_d == S_HALT);
      if (state_d == S_FETCH) imem_addr <= pc_d;
      if (state_q == S_CAPT) instr <= imem_data;
      // Pointer wraps naturally; a push at full overwrites the oldest slot.
      if (do_push) begin
        rs_mem[sp_q] <= pc_inc;
        sp_q         <= sp_q + SP_W'(1);
        if (cnt_q != CNT_FULL) cnt_q <= cnt_q + CNT_W'(1);
      end else if (do_pop) begin
        sp_q <= sp_dec;
        if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

`ifdef INSTR_FETCH_RS_CHECK_EN
  // Sticky stack error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       rs_err <= 1'b0;
    else if (err_set) rs_err <= 1'b1;
  end
`else
  assign rs_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Randomized self-checking bench for instr_fetch_issue against a program-level reference model.
module tb_instr_fetch_issue;

  localparam int unsigned PC_W     = 10;
  localparam int unsigned RS_DEPTH = 8;
  localparam int          MEM_N    = 1 << PC_W;
  localparam logic [15:0] W_HALT   = 16'hFC00;
  localparam logic [15:0] W_POP    = 16'hE000;
`ifdef INSTR_FETCH_RS_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, start, imem_rd, instr_valid, instr_ready, halted, rs_err;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_data, instr;
  logic [15:0]     rom [MEM_N];

  instr_fetch_issue #(.PC_W(PC_W), .RS_DEPTH(RS_DEPTH)) u_dut (
    .clk(clk), .reset(reset), .start(start), .imem_rd(imem_rd), .imem_addr(imem_addr),
    .imem_data(imem_data), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .halted(halted), .rs_err(rs_err)
  );

  always @(posedge clk) if (imem_rd) imem_data <= rom[imem_addr];

  // Narrow-pc instance used for the address wrap check.
  logic        w_reset, w_start, w_rd, w_valid, w_ready, w_halted, w_err;
  logic [3:0]  w_addr;
  logic [15:0] w_data, w_instr;
  logic [15:0] rom_w [16];

  instr_fetch_issue #(.PC_W(4), .RS_DEPTH(RS_DEPTH)) u_wrap (
    .clk(clk), .reset(w_reset), .start(w_start), .imem_rd(w_rd), .imem_addr(w_addr),
    .imem_data(w_data), .instr(w_instr), .instr_valid(w_valid),
    .instr_ready(w_ready), .halted(w_halted), .rs_err(w_err)
  );

  always @(posedge clk) if (w_rd) w_data <= rom_w[w_addr];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  int          exp_addr[$];
  logic [15:0] exp_instr[$];
  bit          exp_halt, exp_err;
  int          got_addr[$];
  logic [15:0] got_instr[$];
  int          got_cyc[$];

  // Architectural model: walk the program, recording fetch addresses and issued words.
  task automatic model_run(input int max_fetch);
    int pc, nxt, g, op, imm, rp, occ;
    int ring[RS_DEPTH];
    logic [15:0] w;
    exp_addr.delete(); exp_instr.delete();
    exp_halt = 0; exp_err = 0;
    pc = 0; rp = 0; occ = 0;
    foreach (ring[i]) ring[i] = 0;
    for (int n = 0; n <= max_fetch; n++) begin
      exp_addr.push_back(pc);
      if (n == max_fetch) break;
      w   = rom[pc];
      g   = int'(w[15:13]);
      op  = int'(w[12:10]);
      imm = int'(w[9:0]) % MEM_N;
      nxt = (pc + 1) % MEM_N;
      if (g == 6) begin
        if (CHK && occ == RS_DEPTH) begin exp_err = 1; exp_halt = 1; break; end
        ring[rp] = nxt; rp = (rp + 1) % RS_DEPTH;
        if (occ < RS_DEPTH) occ++;
        pc = imm;
      end else if (g == 7 && op == 0) begin
        if (CHK && occ == 0) begin exp_err = 1; exp_halt = 1; break; end
        rp = (rp + RS_DEPTH - 1) % RS_DEPTH; pc = ring[rp];
        if (occ > 0) occ--;
      end else if (g == 7 && op == 7) begin
        exp_halt = 1; break;
      end else if (g == 7) begin
        pc = nxt;
      end else begin
        exp_instr.push_back(w); pc = nxt;
      end
    end
  endtask

  // Reset, start, then monitor until halt or one fetch past the budget.
  task automatic run_dut(input int max_fetch, input int rmode);
    bit in_valid, done;
    int vcyc;
    logic [15:0] held;
    got_addr.delete(); got_instr.delete(); got_cyc.delete();
    in_valid = 0; done = 0; vcyc = 0; held = '0;
    reset = 1'b0; start = 1'b0; instr_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (instr_valid) begin
        if (!in_valid) begin in_valid = 1; held = instr; vcyc = 0; end
        else begin vcyc++; check("instr_hold", 32'(instr), 32'(held)); end
      end
      case (rmode)
        0:       instr_ready = 1'b1;
        1:       instr_ready = 1'($urandom_range(0, 1));
        default: instr_ready = instr_valid && (vcyc >= 5);
      endcase
      if (instr_valid) check("no_rd_in_issue", 32'(imem_rd), 32'd0);
      if (instr_valid && instr_ready) begin
        got_instr.push_back(instr);
        got_cyc.push_back(cyc);
        if (rmode == 2) check("stall_cycles", 32'(vcyc), 32'd5);
        in_valid = 0;
      end
      if (imem_rd) begin
        got_addr.push_back(int'(imem_addr));
        if (got_addr.size() > max_fetch) begin done = 1; break; end
      end
      if (halted) begin done = 1; break; end
    end
    if (!done) check("run_timeout", 32'd1, 32'd0);
    instr_ready = 1'b0;
  endtask

  task automatic compare_run(input string name);
    check({name, "_naddr"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
      check($sformatf("%s_addr%0d", name, i), 32'(got_addr[i]), 32'(exp_addr[i]));
    check({name, "_ninstr"}, 32'(got_instr.size()), 32'(exp_instr.size()));
    for (int i = 0; i < got_instr.size() && i < exp_instr.size(); i++)
      check($sformatf("%s_instr%0d", name, i), 32'(got_instr[i]), 32'(exp_instr[i]));
    check({name, "_halted"}, 32'(halted), 32'(exp_halt));
    check({name, "_rs_err"}, 32'(rs_err), 32'(exp_err));
  endtask

  task automatic fill_rom(input logic [15:0] w);
    foreach (rom[i]) rom[i] = w;
  endtask

  task automatic random_rom();
    int r;
    foreach (rom[i]) begin
      r = $urandom_range(0, 99);
      if (r < 60)      rom[i] = {3'($urandom_range(0, 5)), 13'($urandom)};
      else if (r < 72) rom[i] = {6'b110_000, 10'($urandom_range(0, 63))};
      else if (r < 84) rom[i] = {6'b111_000, 10'($urandom)};
      else if (r < 94) rom[i] = {3'b111, 3'($urandom_range(1, 6)), 10'($urandom)};
      else             rom[i] = {6'b111_111, 10'($urandom)};
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; instr_ready = 1'b0;
    w_reset = 1'b0; w_start = 1'b0; w_ready = 1'b0;
    fill_rom(W_HALT);

    // Asynchronous reset values
    #3 reset = 1'b0;
    #1;
    check("rst_imem_rd", 32'(imem_rd), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_rs_err", 32'(rs_err), 32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_rd", 32'(imem_rd), 32'd0);

    // Sequential issue at full throughput
    fill_rom(W_HALT);
    rom[0] = 16'h0001; rom[1] = 16'h2005; rom[2] = W_HALT;
    model_run(20); run_dut(20, 0); compare_run("seq");
    check("seq_i0", 32'(got_instr.size() > 0 ? got_instr[0] : 16'hxxxx), 32'h0001);
    check("seq_i1", 32'(got_instr.size() > 1 ? got_instr[1] : 16'hxxxx), 32'h2005);
    check("seq_gap", 32'(got_cyc.size() > 1 ? got_cyc[1] - got_cyc[0] : -1), 32'd3);

    // Backpressure: five stalled cycles per instruction
    fill_rom(W_HALT);
    rom[0] = 16'h0001; rom[1] = 16'h4123; rom[2] = 16'h1FFF; rom[3] = W_HALT;
    model_run(20); run_dut(20, 2); compare_run("bp");

    // Call/return; neither control word is issued
    fill_rom(W_HALT);
    rom[0] = 16'hC00A; rom[10] = W_POP; rom[1] = W_HALT;
    model_run(20); run_dut(20, 1); compare_run("call");
    check("call_a1", 32'(got_addr.size() > 1 ? got_addr[1] : -1), 32'd10);
    check("call_a2", 32'(got_addr.size() > 2 ? got_addr[2] : -1), 32'd1);

    // Nine nested calls into an eight-deep stack
    fill_rom(W_POP);
    for (int i = 0; i < 9; i++) rom[2*i] = {6'b110_000, 10'(2*i + 2)};
    model_run(25); run_dut(25, 0); compare_run("ovf");
`ifdef INSTR_FETCH_RS_CHECK_EN
    check("ovf_err", 32'(rs_err), 32'd1);
    check("ovf_halt", 32'(halted), 32'd1);
`else
    check("ovf_ret9", 32'(got_addr.size() > 18 ? got_addr[18] : -1), 32'd17);
    check("ovf_noerr", 32'(rs_err), 32'd0);
`endif

    // Random programs with random backpressure
    for (int t = 0; t < 8; t++) begin
      random_rom();
      model_run(40); run_dut(40, 1); compare_run($sformatf("rnd%0d", t));
    end

    // Reset mid-issue, then restart from address 0
    fill_rom(W_HALT);
    rom[0] = 16'h0042;
    reset = 1'b0; start = 1'b0; instr_ready = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    begin
      bit seen;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        seen = instr_valid;
      end
      check("mid_valid_seen", 32'(seen), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("mid_valid_drop", 32'(instr_valid), 32'd0);
      check("mid_instr_clr", 32'(instr), 32'd0);
      check("mid_rd_clr", 32'(imem_rd), 32'd0);
      @(negedge clk); reset = 1'b1;
      @(negedge clk); start = 1'b1;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        start = 1'b0;
        seen = imem_rd;
      end
      check("mid_refetch", 32'(seen), 32'd1);
      check("mid_refetch_addr", 32'(imem_addr), 32'd0);
    end

    // Program counter wrap on the 4-bit instance
    foreach (rom_w[i]) rom_w[i] = 16'h0100 + 16'(i);
    @(negedge clk); w_reset = 1'b1;
    @(negedge clk); w_start = 1'b1; w_ready = 1'b1;
    begin
      int wa[$];
      logic [15:0] wi[$];
      for (int c = 0; c < 200 && wa.size() < 17; c++) begin
        @(negedge clk);
        w_start = 1'b0;
        if (w_valid) wi.push_back(w_instr);
        if (w_rd) wa.push_back(int'(w_addr));
      end
      check("wrap_nfetch", 32'(wa.size()), 32'd17);
      for (int i = 0; i < wa.size(); i++)
        check($sformatf("wrap_addr%0d", i), 32'(wa[i]), 32'(i % 16));
      check("wrap_i15", 32'(wi.size() > 15 ? wi[15] : 16'hxxxx), 32'h010F);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
